fs_cap_multi: RTL and testbench

FS_CAP_MULTI -- requirements
Module: fs_cap_multi

---
 rtl/fs_cap_multi.sv | 68 ++++++
 tb/tb_fs_cap_multi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fs_cap_multi.sv
// fs_cap_multi: per-channel vsync synchroniser, debouncer and frame-start capture with decimation and back-pressure.
// Define FS_CAP_FRAME_CNT_EN to add per-channel 16-bit capture counters on frame_cnt_o.
module fs_cap_multi #(
  parameter int CH_NUM      = 2,
  parameter int SYNC_STAGES = 4,
  parameter int DEB_THR     = 20,
  parameter bit VS_POL      = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [CH_NUM-1:0]      vs_i,
  input  logic [CH_NUM-1:0]      en_i,
  input  logic [4*CH_NUM-1:0]    skip_i,
  input  logic [CH_NUM-1:0]      s_rdy_i,
  input  logic                   clr_i,
  output logic [CH_NUM-1:0]      fs_cap_o,
  output logic [CH_NUM-1:0]      ovf_o,
  output logic [16*CH_NUM-1:0]   frame_cnt_o
);
  localparam int CW = $clog2(DEB_THR + 1);
  localparam logic [CW-1:0] THR = CW'(DEB_THR);
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] act_cnt, ina_cnt;
    logic [3:0] dec, k;
    logic filt, filt_q, ev, pend, cap, ovf, lvl, acc, fire;
    assign k    = skip_i[4*c +: 4];
    assign lvl  = VS_POL ? sync[SYNC_STAGES-1] : ~sync[SYNC_STAGES-1];
    assign acc  = ev & en_i[c] & (dec == 4'd0);
    // a capture issued last cycle holds off the next one so pulses never merge
    assign fire = en_i[c] & (acc | pend) & s_rdy_i[c] & ~cap;
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
        sync    <= {SYNC_STAGES{VS_POL}};
        act_cnt <= '0;
        ina_cnt <= '0;
        filt    <= 1'b1;
        filt_q  <= 1'b1;
        ev      <= 1'b0;
        dec     <= '0;
        pend    <= 1'b0;
        cap     <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        sync    <= {sync[SYNC_STAGES-2:0], vs_i[c]};
        act_cnt <= !lvl ? '0 : (act_cnt == THR) ? THR : act_cnt + 1'b1;
        ina_cnt <= lvl ? '0 : (ina_cnt == THR) ? THR : ina_cnt + 1'b1;
        filt    <= (act_cnt == THR) ? 1'b1 : (ina_cnt == THR) ? 1'b0 : filt;
        filt_q  <= filt;
        ev      <= filt & ~filt_q;
        dec     <= !en_i[c] ? 4'd0 : !ev ? dec : (dec == k) ? 4'd0 : dec + 4'd1;
        pend    <= en_i[c] & ~fire & (pend | acc);
        cap     <= fire;
        ovf     <= ~clr_i & (ovf | (acc & pend));
      end
    assign fs_cap_o[c] = cap;
    assign ovf_o[c]    = ovf;
`ifdef FS_CAP_FRAME_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) cnt <= '0;
      else cnt <= clr_i ? 16'd0 : cnt + 16'(cap);
    assign frame_cnt_o[16*c +: 16] = cnt;
`else
    assign frame_cnt_o[16*c +: 16] = 16'd0;
`endif
  end
endmodule

// File: tb/tb_fs_cap_multi.sv
// tb_fs_cap_multi: directed stimulus with a cycle-level behavioural model compared every clock,
// plus literal checks on latency, pulse counts, overflow, clear and reset behaviour.
module tb_fs_cap_multi;
  localparam int CH = 2;
  localparam int S = 4;
  localparam int D = 20;
  localparam bit VS_POL = 1'b1;

  logic clk = 0;
  logic rstn = 1;
  logic [CH-1:0] vs = '0, en = '1, rdy = '1;
  logic [4*CH-1:0] skip = '0;
  logic clr = 0;
  logic [CH-1:0] fs_cap, ovf;
  logic [16*CH-1:0] frame_cnt;

  fs_cap_multi #(.CH_NUM(CH), .SYNC_STAGES(S), .DEB_THR(D), .VS_POL(VS_POL)) dut (
    .clk_i(clk), .rstn_i(rstn), .vs_i(vs), .en_i(en), .skip_i(skip), .s_rdy_i(rdy),
    .clr_i(clr), .fs_cap_o(fs_cap), .ovf_o(ovf), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int pc[CH], lp[CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: raw sync pipe, recent normalised samples, filtered-level history, capture bookkeeping
  bit q[CH][$];
  bit hist[CH][$];
  bit fh[CH][3];
  bit m_cap[CH], m_pend[CH], m_ovf[CH];
  int m_dec[CH];
  logic [15:0] m_cnt[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      q[c].delete();
      for (int i = 0; i < S; i++) q[c].push_back(VS_POL);
      hist[c].delete();
      for (int i = 0; i < 3; i++) fh[c][i] = 1'b1;
      m_cap[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_dec[c] = 0; m_cnt[c] = '0;
    end
  endtask

  task automatic step(input int c);
    bit lvl, fnew, ev, acc, fire, same;
    lvl = (q[c][0] == VS_POL);
    fnew = fh[c][2];
    // filtered level follows the input once D consecutive equal samples are seen
    if (hist[c].size() >= D) begin
      same = 1;
      for (int i = hist[c].size() - D; i < hist[c].size(); i++)
        if (hist[c][i] != hist[c][hist[c].size()-1]) same = 0;
      if (same) fnew = hist[c][hist[c].size()-1];
    end
    hist[c].push_back(lvl);
    if (hist[c].size() > D) void'(hist[c].pop_front());
    ev = fh[c][1] && !fh[c][0];
    fh[c][0] = fh[c][1]; fh[c][1] = fh[c][2]; fh[c][2] = fnew;
    void'(q[c].pop_front());
    q[c].push_back(vs[c]);
    acc = ev && en[c] && m_dec[c] == 0;
    fire = en[c] && (acc || m_pend[c]) && rdy[c] && !m_cap[c];
    if (!en[c]) m_dec[c] = 0;
    else if (ev) m_dec[c] = (m_dec[c] == int'(skip[4*c +: 4])) ? 0 : m_dec[c] + 1;
    m_ovf[c] = !clr && (m_ovf[c] || (acc && m_pend[c]));
    m_cnt[c] = clr ? 16'd0 : m_cnt[c] + 16'(m_cap[c]);
    m_pend[c] = en[c] && !fire && (m_pend[c] || acc);
    m_cap[c] = fire;
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) model_reset();
    else for (int c = 0; c < CH; c++) step(c);

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("cyc%0d fs_cap[%0d]", cyc, c), 64'(fs_cap[c]), 64'(m_cap[c]));
      chk($sformatf("cyc%0d ovf[%0d]", cyc, c), 64'(ovf[c]), 64'(m_ovf[c]));
`ifdef FS_CAP_FRAME_CNT_EN
      chk($sformatf("cyc%0d frame_cnt[%0d]", cyc, c), 64'(frame_cnt[16*c +: 16]), 64'(m_cnt[c]));
`else
      chk($sformatf("cyc%0d frame_cnt[%0d]", cyc, c), 64'(frame_cnt[16*c +: 16]), 64'd0);
`endif
      if (fs_cap[c] === 1'b1) begin
        pc[c]++;
        lp[c] = cyc;
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [CH-1:0] m, input int hi, input int lo);
    vs = m; wait_n(hi);
    vs = '0; wait_n(lo);
  endtask

  int p0, p1, t0;

  initial begin
    model_reset();
    for (int c = 0; c < CH; c++) begin pc[c] = 0; lp[c] = 0; end
    #1 rstn = 0;
    wait_n(3);
    chk("reset_outputs", 64'({fs_cap, ovf, frame_cnt}), 64'd0);
    rstn = 1;
    // single frame: latency and no pulse on the falling edge
    wait_n(100);
    p0 = pc[0]; vs[0] = 1; t0 = cyc + 1;
    wait_n(100);
    chk("t1_pulses", 64'(pc[0] - p0), 64'd1);
    chk("t1_latency", 64'(lp[0] - t0), 64'd26);
    p0 = pc[0]; vs[0] = 0; wait_n(100);
    chk("t1_fall", 64'(pc[0] - p0), 64'd0);
    // glitch rejection
    p0 = pc[0]; frame(2'b01, 15, 100);
    chk("t2_glitch15", 64'(pc[0] - p0), 64'd0);
    p0 = pc[0]; frame(2'b01, 20, 100);
    chk("t2_high20", 64'(pc[0] - p0), 64'd1);
    // back-pressure: pending released by ready
    rdy[0] = 0; p0 = pc[0]; vs[0] = 1; wait_n(75);
    chk("t3_held", 64'(pc[0] - p0), 64'd0);
    rdy[0] = 1; t0 = cyc + 1; wait_n(10);
    chk("t3_pulses", 64'(pc[0] - p0), 64'd1);
    chk("t3_when", 64'(lp[0]), 64'(t0));
    chk("t3_ovf", 64'(ovf[0]), 64'd0);
    vs[0] = 0; wait_n(100);
    // overflow then clear
    rdy[0] = 0; frame(2'b01, 60, 60); frame(2'b01, 60, 60);
    chk("t4_ovf", 64'(ovf[0]), 64'd1);
    p0 = pc[0]; rdy[0] = 1; wait_n(5);
    chk("t4_pulses", 64'(pc[0] - p0), 64'd1);
    clr = 1; wait_n(1); clr = 0; wait_n(1);
    chk("t4_ovf_clr", 64'(ovf[0]), 64'd0);
    chk("t4_cnt_clr", 64'(frame_cnt[15:0]), 64'd0);
    // decimation K=2
    skip[3:0] = 4'd2;
    for (int i = 0; i < 6; i++) begin
      p0 = pc[0]; frame(2'b01, 40, 40);
      chk($sformatf("t5_frame%0d", i + 1), 64'(pc[0] - p0), (i == 0 || i == 3) ? 64'd1 : 64'd0);
    end
`ifdef FS_CAP_FRAME_CNT_EN
    chk("t5_cnt", 64'(frame_cnt[15:0]), 64'd2);
`else
    chk("t5_cnt", 64'(frame_cnt[15:0]), 64'd0);
`endif
    skip[3:0] = 4'd0;
    // disabled channel ignores frames
    en[0] = 0; p0 = pc[0]; frame(2'b01, 60, 60);
    chk("t6_disabled", 64'(pc[0] - p0), 64'd0);
    en[0] = 1;
    // simultaneous channels
    p0 = pc[0]; p1 = pc[1]; frame(2'b11, 60, 60);
    chk("t7_ch0", 64'(pc[0] - p0), 64'd1);
    chk("t7_ch1", 64'(pc[1] - p1), 64'd1);
    chk("t7_same_cycle", 64'(lp[0]), 64'(lp[1]));
    // reset while pending
    rdy[0] = 0; frame(2'b01, 60, 60); frame(2'b01, 60, 60);
    vs[0] = 1; wait_n(60);
    chk("t8_ovf_before", 64'(ovf[0]), 64'd1);
    rstn = 0; #1;
    chk("t8_async_reset", 64'({fs_cap, ovf, frame_cnt}), 64'd0);
    wait_n(3);
    rstn = 1; rdy[0] = 1; p0 = pc[0]; wait_n(100);
    chk("t8_no_pulse", 64'(pc[0] - p0), 64'd0);
    vs[0] = 0; wait_n(100);
    p0 = pc[0]; frame(2'b01, 100, 20);
    chk("t8_new_frame", 64'(pc[0] - p0), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
